alu_arbiter: RTL

Shares one instance of the team's 16-bit combinational `alu` between two requesters using valid/ready handshakes and round-robin arbitration. The block latches the winner's operands and opcode, then runs the ALU for one cycle. It registers the result with a zero flag and an illegal-opcode flag, and holds the response until the owning requester accepts it. It sits between the two datapath clients and the shared ALU, so the `alu` is never instantiated twice.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu.sv | 28 ++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, arbiter FSM states and opcode classification helpers.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_NE  = 4'b1001;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_SGE = 4'b1101;
    localparam logic [3:0] OP_ULT = 4'b1110;
    localparam logic [3:0] OP_UGE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operands and opcode captured from the granted requester.
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [3:0]       sel;
    } req_t;

    // Compares produce a single-bit answer in result[0].
    function automatic logic is_cmp(input logic [3:0] sel);
        case (sel)
            OP_EQ, OP_NE, OP_SLT, OP_SGE, OP_ULT, OP_UGE: is_cmp = 1'b1;
            default:                                      is_cmp = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] sel);
        case (sel)
            OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SUB,
            OP_EQ, OP_NE, OP_SLT, OP_SGE, OP_ULT, OP_UGE: is_legal = 1'b1;
            default:                                      is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// 16-bit combinational ALU: add, sub, logic ops, equality and unsigned compares.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [3:0]       sel,
    output logic [ALU_W-1:0] y
);

    // Opcode decode; unsupported opcodes yield zero.
    always_comb begin
        y = '0;
        case (sel)
            OP_ADD: y = a + b;
            OP_XOR: y = a ^ b;
            OP_OR:  y = a | b;
            OP_AND: y = a & b;
            OP_SUB: y = a - b;
            OP_EQ:  y = {{(ALU_W-1){1'b0}}, a == b};
            OP_NE:  y = {{(ALU_W-1){1'b0}}, a != b};
            OP_ULT: y = {{(ALU_W-1){1'b0}}, a <  b};
            OP_UGE: y = {{(ALU_W-1){1'b0}}, a >= b};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu between two valid/ready requesters.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][W-1:0]   req_a,
    input  logic [1:0][W-1:0]   req_b,
    input  logic [1:0][3:0]     req_sel,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [W-1:0]        resp_result,
    output logic                resp_zero,
    output logic                resp_illegal,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    state_t           state, state_nxt;
    logic             rr_ptr;
    logic             owner;
    logic             gnt;
    logic             any_vld;
    req_t             lat;
    logic [W-1:0]     alu_a, alu_b, alu_y, masked;
    logic [3:0]       alu_sel;

    // Priority to rr_ptr, fall back to the other requester.
    always_comb begin
        any_vld = |req_valid;
        gnt     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (any_vld) begin
                req_ready[gnt] = 1'b1;
                state_nxt      = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Signed compares become unsigned ones on sign-flipped operands.
    always_comb begin
        alu_a   = lat.a;
        alu_b   = lat.b;
        alu_sel = lat.sel;
        if (lat.sel == OP_SLT || lat.sel == OP_SGE) begin
            alu_a   = lat.a ^ 16'h8000;
            alu_b   = lat.b ^ 16'h8000;
            alu_sel = (lat.sel == OP_SLT) ? OP_ULT : OP_UGE;
        end
    end

    alu u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .sel (alu_sel),
        .y   (alu_y)
    );

    // Illegal opcodes never reach the result; compares keep only bit 0.
    always_comb begin
        masked = alu_y;
        if (!is_legal(lat.sel))  masked = '0;
        else if (is_cmp(lat.sel)) masked = {{(W-1){1'b0}}, alu_y[0]};
    end

    // FSM state, ownership and operand capture on the grant handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            lat   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_vld) begin
                owner   <= gnt;
                lat.a   <= req_a[gnt];
                lat.b   <= req_b[gnt];
                lat.sel <= req_sel[gnt];
            end
        end
    end

    // Response registers, loaded in EXEC and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_result  <= '0;
            resp_zero    <= 1'b0;
            resp_illegal <= 1'b0;
        end else if (state == EXEC) begin
            resp_result  <= masked;
            resp_zero    <= (masked == '0);
            resp_illegal <= !is_legal(lat.sel);
        end
    end

    // Completion bookkeeping: hand priority to the other side, count the op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            op_count <= '0;
        end else if (state == RESP && resp_ready[owner]) begin
            rr_ptr   <= ~owner;
            op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
